// File: rtl/axis_window_mean_pkg.sv
// Shared DSP helpers for the averaging stages: sample type, log2 and accumulator sizing.
// No logic here; only types and constant functions.
// Used at elaboration time to size adders, accumulators and counters.
package axis_window_mean_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;

  typedef logic signed [DEFAULT_SAMPLE_WIDTH-1:0] int_t;

  // Ceiling log2; exact for powers of two, log2(1) = 0.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width that cannot overflow for a full window of full-scale samples.
  function automatic int acc_width(input int sample_width, input int parallel_samples,
                                   input int max_window_log2);
    return sample_width + log2(parallel_samples) + max_window_log2;
  endfunction

endpackage

// File: rtl/axis_window_mean_parallel_sum.sv
// Registered signed sum of PARALLEL_SAMPLES packed samples, reusable by averaging stages.
// Latency: one cycle from en to sum.
// Backpressure: none internally; the sum register only updates while en is high.
module axis_window_mean_parallel_sum
  import axis_window_mean_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 2,
  localparam int SUM_W           = SAMPLE_WIDTH + log2(PARALLEL_SAMPLES)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     en,
  input  logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] samples,
  output logic signed [SUM_W-1:0]                  sum
);

  logic signed [SUM_W-1:0] sum_comb;

  // Sign-extend every lane to the growth width and add them all.
  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
      sum_comb = sum_comb + SUM_W'($signed(samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
    end
  end

  // Capture the lane sum on each enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_comb;
    end
  end

endmodule

// File: rtl/axis_window_mean.sv
// Windowed mean power: sums 2^win beats of squared samples and emits sum >>> (win + log2(P)).
// Latency: final beat of a window accepted at cycle t gives data_out_valid at t+2.
// Backpressure: data_in_ready = ~(data_out_valid & ~data_out_ready); the whole pipe holds on stall.
module axis_window_mean
  import axis_window_mean_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 2,
  parameter int MAX_WINDOW_LOG2  = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [$clog2(MAX_WINDOW_LOG2+1)-1:0]     window_log2,
  input  logic                                     data_in_valid,
  output logic                                     data_in_ready,
  input  logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] data_in_data,
  input  logic                                     data_in_last,
  output logic                                     data_out_valid,
  input  logic                                     data_out_ready,
  output logic [SAMPLE_WIDTH-1:0]                  data_out_data,
  output logic                                     data_out_last
);

  localparam int L2P     = log2(PARALLEL_SAMPLES);
  localparam int SUM_W   = SAMPLE_WIDTH + L2P;
  localparam int ACC_W   = acc_width(SAMPLE_WIDTH, PARALLEL_SAMPLES, MAX_WINDOW_LOG2);
  localparam int WIN_W   = $clog2(MAX_WINDOW_LOG2 + 1);
  localparam int CNT_W   = (MAX_WINDOW_LOG2 > 0) ? MAX_WINDOW_LOG2 : 1;
  localparam int SHIFT_W = $clog2(ACC_W + 1);

  // Frame boundaries come from the window counter, not from tlast.
  logic unused_last;
  assign unused_last = data_in_last;

  logic stall;
  logic accept;

  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_new;
  logic [WIN_W-1:0] win_eff;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] end_cnt;
  logic             beat_end;

  logic                    s1_valid;
  logic                    s1_end;
  logic [WIN_W-1:0]        s1_win;
  logic signed [SUM_W-1:0] s1_sum;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] s1_ext;
  logic signed [ACC_W-1:0] total;
  logic signed [ACC_W-1:0] shifted;
  logic [SHIFT_W-1:0]      shift;

  assign stall          = data_out_valid & ~data_out_ready;
  assign data_in_ready  = ~stall & ~reset;
  assign accept         = data_in_valid & data_in_ready;
  assign data_out_last  = 1'b0;

  // Window length in force for the beat on the input: a fresh clamped value at window start,
  // otherwise the value latched when the current window began.
  always_comb begin
    win_new = window_log2;
    if (window_log2 > WIN_W'(MAX_WINDOW_LOG2)) win_new = WIN_W'(MAX_WINDOW_LOG2);
    win_eff  = (beat_cnt == '0) ? win_new : win_q;
    end_cnt  = ~({CNT_W{1'b1}} << win_eff);
    beat_end = (beat_cnt == end_cnt);
  end

  axis_window_mean_parallel_sum #(
    .SAMPLE_WIDTH    (SAMPLE_WIDTH),
    .PARALLEL_SAMPLES(PARALLEL_SAMPLES)
  ) u_parallel_sum (
    .clk    (clk),
    .reset  (reset),
    .en     (accept),
    .samples(data_in_data),
    .sum    (s1_sum)
  );

  // Stage 1 control: beat counting, window latch and end-of-window flag travel with the lane sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      win_q    <= '0;
      s1_valid <= 1'b0;
      s1_end   <= 1'b0;
      s1_win   <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_end   <= beat_end;
        s1_win   <= win_eff;
        beat_cnt <= beat_end ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == '0) win_q <= win_new;
      end
    end
  end

  // Final sum of the window and the floor-mean shift by the total sample count.
  always_comb begin
    s1_ext  = ACC_W'(s1_sum);
    total   = acc + s1_ext;
    shift   = SHIFT_W'(s1_win) + SHIFT_W'(L2P);
    shifted = total >>> shift;
  end

  // Stage 2: accumulate, and on window end load the result and restart the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc            <= '0;
      data_out_valid <= 1'b0;
      data_out_data  <= '0;
    end else if (!stall) begin
      data_out_valid <= 1'b0;
      if (s1_valid) begin
        if (s1_end) begin
          data_out_data  <= shifted[SAMPLE_WIDTH-1:0];
          data_out_valid <= 1'b1;
          acc            <= '0;
        end else begin
          acc <= total;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_window_mean.sv
// Self-checking bench for axis_window_mean: directed windows with literal results plus a
// random valid/ready run checked against a window-level arithmetic model.
module tb_axis_window_mean;

  localparam int SW  = 16;
  localparam int P   = 2;
  localparam int MAXW = 16;

  logic        clk;
  logic        reset;
  logic [4:0]  window_log2;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [31:0] data_in_data;
  logic        data_in_last;
  logic        data_out_valid;
  logic        data_out_ready;
  logic [15:0] data_out_data;
  logic        data_out_last;

  axis_window_mean #(
    .SAMPLE_WIDTH    (SW),
    .PARALLEL_SAMPLES(P),
    .MAX_WINDOW_LOG2 (MAXW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .window_log2   (window_log2),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_in_data  (data_in_data),
    .data_in_last  (data_in_last),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_data (data_out_data),
    .data_out_last (data_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Window-level model: collect accepted beats, and when the window is full push floor(mean).
  longint exp_q[$];
  longint model_sum = 0;
  int     model_cnt = 0;
  int     model_w   = 0;

  logic signed [15:0] got_dat[$];
  int     got_cyc[$];
  int     last_acc_cyc = 0;
  int     out_total = 0;

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic        prev_reset = 1'b0;
  logic        last_in_hs = 1'b0;

  // Per-cycle monitor and compare process, sampled on the falling edge.
  always @(negedge clk) begin
    logic stall_now;
    stall_now = data_out_valid & ~data_out_ready;
    chk("out_last", data_out_last, 0);
    if (reset) begin
      model_sum = 0;
      model_cnt = 0;
      exp_q.delete();
      chk("reset_in_ready", data_in_ready, 0);
      if (prev_reset) begin
        chk("reset_out_valid", data_out_valid, 0);
        chk("reset_out_data", data_out_data, 0);
      end
    end else begin
      chk("in_ready_vs_stall", data_in_ready, !stall_now);
      if (prev_stall) begin
        chk("stall_hold_valid", data_out_valid, 1);
        chk("stall_hold_data", data_out_data, prev_data);
      end
      if (data_out_valid && data_out_ready) begin
        out_total++;
        got_dat.push_back(data_out_data);
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("out_data", longint'($signed(data_out_data)), exp_q.pop_front());
      end
      if (data_in_valid && data_in_ready) begin
        last_acc_cyc = cyc;
        if (model_cnt == 0) model_w = (window_log2 > MAXW) ? MAXW : int'(window_log2);
        model_sum += longint'($signed(data_in_data[15:0])) + longint'($signed(data_in_data[31:16]));
        model_cnt++;
        if (model_cnt == (1 << model_w)) begin
          exp_q.push_back(floor_div(model_sum, longint'(P) << model_w));
          model_sum = 0;
          model_cnt = 0;
        end
      end
    end
    prev_stall = stall_now && !reset;
    prev_data  = data_out_data;
    prev_reset = reset;
    last_in_hs = data_in_valid && data_in_ready;
  end

  // Offer one beat starting at posedge+1 and return at posedge+1 after its handshake.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    logic hs;
    hs = 1'b0;
    data_in_data  = {b, a};
    data_in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      hs = data_in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
    end
    if (!hs) chk("send_timeout", 0, 1);
    data_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    window_log2    = 5'd2;
    data_in_valid  = 1'b0;
    data_in_data   = '0;
    data_in_last   = 1'b0;
    data_out_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Constant 0x1000 window of 4 beats; latency from final accept to output is 2.
    got_dat.delete(); got_cyc.delete();
    repeat (4) send(16'h1000, 16'h1000);
    idle(6);
    chk("t1_count", got_dat.size(), 1);
    if (got_dat.size() >= 1) begin
      chk("t1_data", got_dat[0], 16'sh1000);
      chk("t1_latency", got_cyc[0] - last_acc_cyc, 2);
    end

    // Floor behaviour: 1..8 -> 4, all -3 -> -3, alternating -1,0 -> -1.
    got_dat.delete(); got_cyc.delete();
    send(1, 2); send(3, 4); send(5, 6); send(7, 8);
    repeat (4) send(-16'sd3, -16'sd3);
    repeat (4) send(-16'sd1, 16'sd0);
    idle(6);
    chk("t2_count", got_dat.size(), 3);
    if (got_dat.size() >= 3) begin
      chk("t2_ramp", got_dat[0], 4);
      chk("t2_neg3", got_dat[1], -3);
      chk("t2_alt", got_dat[2], -1);
    end

    // Single-beat windows with extreme values, back to back.
    window_log2 = 5'd0;
    got_dat.delete(); got_cyc.delete();
    send(5, 6); send(16'h7FFF, 16'h7FFF); send(16'h8000, 16'h8000);
    idle(6);
    chk("t3_count", got_dat.size(), 3);
    if (got_dat.size() >= 3) begin
      chk("t3_small", got_dat[0], 5);
      chk("t3_max", got_dat[1], 32767);
      chk("t3_min", got_dat[2], -32768);
      chk("t3_throughput", got_cyc[2] - got_cyc[0], 2);
    end

    // Reset mid-window discards the partial sum.
    window_log2 = 5'd2;
    got_dat.delete(); got_cyc.delete();
    send(100, 100); send(100, 100);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    repeat (4) send(8, 8);
    idle(6);
    chk("t4_count", got_dat.size(), 1);
    if (got_dat.size() >= 1) chk("t4_data", got_dat[0], 8);

    // Window change mid-window applies from the next window.
    got_dat.delete(); got_cyc.delete();
    send(4, 4);
    window_log2 = 5'd1;
    repeat (3) send(4, 4);
    send(10, 10); send(10, 10);
    send(-16'sd4, -16'sd4); send(0, 0);
    idle(6);
    chk("t5_count", got_dat.size(), 3);
    if (got_dat.size() >= 3) begin
      chk("t5_old_window", got_dat[0], 4);
      chk("t5_new_window", got_dat[1], 10);
      chk("t5_new_floor", got_dat[2], -2);
    end

    // Random valid/ready traffic with 8-beat windows against the model.
    window_log2 = 5'd3;
    out_total = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!data_in_valid || last_in_hs) begin
        data_in_valid = ($urandom_range(0, 3) != 0);
        data_in_data  = $urandom;
      end
      data_out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    idle(20);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_outputs_seen", (out_total > 50) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_window_mean.md
Name: axis_window_mean

Overview:
- Downstream consumer of the axis_x2 squaring stage.
- Accumulates squared samples (PARALLEL_SAMPLES per beat) over a runtime-selectable window of 2^window_log2 beats.
- Emits one mean-power sample per window: the window sum arithmetically shifted right by log2 of the total sample count.
- Feeds power/level readout and trigger logic.

Parameters:
- SAMPLE_WIDTH, 16, bits per signed input/output sample.
- PARALLEL_SAMPLES, 2, samples per input beat; must be a power of 2, at least 1.
- MAX_WINDOW_LOG2, 16, largest supported window_log2 (window length in beats = 2^window_log2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- window_log2  input  $clog2(MAX_WINDOW_LOG2+1)  log2 of window length in beats; values above MAX_WINDOW_LOG2 clamp to MAX_WINDOW_LOG2.
- data_in  Axis_If slave  DWIDTH=SAMPLE_WIDTH*PARALLEL_SAMPLES  packed signed samples; sample i at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]; last ignored.
- data_out  Axis_If master  DWIDTH=SAMPLE_WIDTH  one signed mean sample per window; last tied 0.

Behaviour:
- Reset (synchronous, active-high) clears:
  - data_out.valid=0, data_out.data=0;
  - beat counter, accumulator and stage-1 valid/end flags;
  - any partially filled window, which is discarded.
- Stall condition: stall = data_out.valid & ~data_out.ready.
  - data_in.ready = ~stall (combinational) and is also forced 0 during reset.
  - All pipeline registers hold while stall is asserted.
- Window length: window_log2 is latched into win_q when a window starts (the first accepted beat after reset or after a window closes).
  - A change to window_log2 mid-window takes effect on the next window.
  - shift = win_q + log2(PARALLEL_SAMPLES).
- Stage 1, on each accepted beat (data_in.ok):
  - Register s1_sum = signed sum of the PARALLEL_SAMPLES samples, width SAMPLE_WIDTH+log2(PARALLEL_SAMPLES).
  - Register s1_valid=1.
  - Register s1_end=1 when beat_cnt == 2^win_q-1.
  - beat_cnt increments, wrapping to 0 on s1_end.
  - If no beat is accepted and there is no stall, s1_valid=0.
- Stage 2, when s1_valid and not stalled:
  - If s1_end:
    - data_out.data = (acc+s1_sum) >>> shift, truncated to SAMPLE_WIDTH.
    - data_out.valid=1.
    - acc=0.
  - Otherwise: acc = acc + s1_sum.
- data_out.valid clears on data_out.ok unless a new result loads in the same cycle.
- Accumulator width: SAMPLE_WIDTH + log2(PARALLEL_SAMPLES) + MAX_WINDOW_LOG2, signed, so it never overflows.
- Rounding: floor (arithmetic shift). The output always fits in SAMPLE_WIDTH, because a mean of in-range values stays in range.
- Latency: final beat of a window accepted at cycle t → data_out.valid at t+2, with no stall.
- Throughput: one beat per cycle while data_out.ready=1.
- window_log2=0: every beat produces an output.
- Simultaneous output handshake and new result in the same cycle: the new result loads and valid stays 1. No bubble and no loss.
- Input valid with output full: the beat is not accepted (ready=0) and the source must hold it.

Decomposition:
- Shared DSP package holds:
  - int_t (signed SAMPLE_WIDTH);
  - acc_width(SAMPLE_WIDTH, PARALLEL_SAMPLES, MAX_WINDOW_LOG2) function;
  - log2 helper.
- Sub-module parallel_sum: registered signed adder of PARALLEL_SAMPLES samples with an enable input. It is reusable by other averaging stages.

Test Plan:
- PARALLEL_SAMPLES=2, window_log2=2, all samples 0x1000 for 4 beats → one output 0x1000, 2 cycles after the 4th accept.
- window_log2=2, samples 1..8 → sum 36 >>> 3 = 4 (floor). Samples all -3 → -3. Samples alternating -1,0 → -1 (floor).
- window_log2=0, beats (5,6),(0x7FFF,0x7FFF),(-0x8000,-0x8000) → outputs 5, 0x7FFF, -0x8000 (extreme-value, no-overflow check).
- 2000 cycles of random data_in.valid/data_out.ready with window_log2=3 → all outputs match the reference model in order; data_out.data stable while valid & ~ready; data_in.ready=0 exactly during stalls.
- Reset asserted after 2 beats of a window_log2=2 window → partial sum discarded; the next output uses only the 4 post-reset beats.
- window_log2 changed 2→1 mid-window → current window still closes after 4 beats; the following windows close every 2 beats with shift=2.
